fetch_control: RTL and testbench
================================

# fetch_control

Instruction fetch stage of the 16-bit CPU pipeline: owns the program counter, issues word requests to instruction memory with a req/ack handshake, buffers returned words in a 2-entry queue, and presents instruction plus PC+1 to the decode stage. It is the producer for the decode stage's instruction and PC+1 inputs. It honours decode back-pressure (stall) and redirects on taken branches, discarding wrong-path words.

## Interface
- REG_WIDTH, 16, PC/address width
- RESET_PC, 'h0, PC value loaded at reset
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- o_R_imem_addr  out  REG_WIDTH  instruction memory word address
- o_1_imem_req  out  1  fetch request, held with stable address until ack
- i_1_imem_ack  in  1  memory completes request; data valid this cycle
- i_16_imem_rdata  in  16  instruction word, valid when ack=1
- i_1_branch  in  1  taken-branch redirect pulse from execute
- i_R_branch_target  in  REG_WIDTH  redirect PC, sampled when branch=1
- i_1_stall  in  1  decode cannot accept this cycle
- o_1_instr_valid  out  1  o_16_instr/o_R_pcplus valid
- o_16_instr  out  16  instruction to decode
- o_R_pcplus  out  REG_WIDTH  address of o_16_instr + 1

## Operation
- States: IDLE, FETCH, DRAIN. Reset -> IDLE; IDLE -> FETCH after one cycle.
- FETCH: o_1_imem_req = (count < 2); o_R_imem_addr = pc. At most one outstanding request.
- On ack in FETCH (no branch): push {rdata, pc+1} into queue; pc <= pc+1.
- Pop when o_1_instr_valid && !i_1_stall. Push and pop in the same cycle allowed; count unchanged.
- o_1_instr_valid = (count != 0); outputs show queue head. Head held stable while stalled.
- Branch (any state): queue flushed (count <= 0), pc <= i_R_branch_target, ack data in that cycle discarded.
  - If a request is outstanding (req=1, ack=0) at branch: -> DRAIN; req deasserted; next ack discarded; then -> FETCH.
  - Otherwise stay/enter FETCH; new request at target next cycle.
- Branch in DRAIN: update pc to new target, stay DRAIN until the pending ack.
- Branch wins over stall and over a simultaneous pop; the popped-then-flushed entry is not presented again.
- PC arithmetic modulo 2^REG_WIDTH; pc+1 at all-ones wraps to 0, pcplus likewise.

## Timing
- Reset values: o_1_imem_req=0, o_R_imem_addr=RESET_PC, o_1_instr_valid=0, o_16_instr=0, o_R_pcplus=0, pc=RESET_PC, count=0, state=IDLE.
- Reset mid-operation: all state returns to reset values next edge; a pending ack after reset is ignored (IDLE/DRAIN semantics not required: memory is reset together).
- First request: cycle 1 after rst deasserts. Ack in same cycle -> o_1_instr_valid in the following cycle (fetch-to-decode latency 1 cycle after ack).
- Zero-wait memory, no stall: one instruction per cycle sustained.
- Branch at cycle N, no outstanding request: req with addr=target at N+1; valid earliest N+2.
- Queue full (count=2): req low until a pop; req reasserts the cycle after the pop.
- All outputs driven from registers, except o_1_imem_req (decoded from state and count).

## Structure
- Shared package cpu_pkg: REG_WIDTH, RESET_PC, INSTR_WIDTH=16, fetch state encoding.
- Sub-module fetch_buffer: 2-entry synchronous FIFO with push, pop, flush (flush dominant), count, head outputs; width INSTR_WIDTH+REG_WIDTH.
- fetch_control holds pc, FSM and handshake logic.

## Test plan
- Reset RESET_PC='h0010, zero-wait ack, no stall -> addresses 0x10,0x11,0x12 on consecutive cycles; decode sees instr words in order with pcplus 0x11,0x12,0x13.
- Stall held 4 cycles after first valid -> head stays constant, count reaches 2, req drops; stall release -> one pop per cycle, req back next cycle.
- Ack delayed 3 cycles -> o_R_imem_addr and req stable throughout; exactly one push on ack.
- Branch to 0x0040 while request to 0x0013 outstanding -> DRAIN, late ack word discarded, next req addr 0x0040, first valid pcplus 0x0041, no wrong-path valid.
- Branch coincident with stall and ack, queue full -> queue flushed, ack data dropped, next req addr = target.
- pc=0xFFFF fetch -> pcplus 0x0000, next address 0x0000; rst asserted mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the 16-bit CPU pipeline stages.
//   REG_WIDTH   - PC / register / address width
//   RESET_PC    - PC value loaded at reset
//   INSTR_WIDTH - instruction word width
//   fetch_state_e - fetch stage FSM states
package cpu_pkg;

    localparam int unsigned REG_WIDTH   = 16;
    localparam int unsigned INSTR_WIDTH = 16;
    localparam logic [REG_WIDTH-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_control_if.sv
// fetch_control_if: fetch stage bus bundle.
//   Instruction memory: o_R_imem_addr, o_1_imem_req, i_1_imem_ack, i_16_imem_rdata
//   Execute redirect  : i_1_branch, i_R_branch_target
//   Decode            : i_1_stall, o_1_instr_valid, o_16_instr, o_R_pcplus
// Modports: master = fetch stage, slave = memory/execute/decode side.
interface fetch_control_if #(
    parameter int unsigned REG_WIDTH = cpu_pkg::REG_WIDTH
);

    logic [REG_WIDTH-1:0] o_R_imem_addr;
    logic                 o_1_imem_req;
    logic                 i_1_imem_ack;
    logic [15:0]          i_16_imem_rdata;
    logic                 i_1_branch;
    logic [REG_WIDTH-1:0] i_R_branch_target;
    logic                 i_1_stall;
    logic                 o_1_instr_valid;
    logic [15:0]          o_16_instr;
    logic [REG_WIDTH-1:0] o_R_pcplus;

    modport master (
        output o_R_imem_addr, o_1_imem_req, o_1_instr_valid, o_16_instr, o_R_pcplus,
        input  i_1_imem_ack, i_16_imem_rdata, i_1_branch, i_R_branch_target, i_1_stall
    );

    modport slave (
        input  o_R_imem_addr, o_1_imem_req, o_1_instr_valid, o_16_instr, o_R_pcplus,
        output i_1_imem_ack, i_16_imem_rdata, i_1_branch, i_R_branch_target, i_1_stall
    );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry synchronous FIFO, head held directly in a register.
//   clk, rst    - clock, synchronous active-high reset
//   push/pop    - enqueue push_data / dequeue head (pop ignored when empty)
//   flush       - empties the queue; dominates push and pop
//   count       - number of valid entries (0..2)
//   head        - oldest entry, registered
module fetch_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q < 2'd2) || do_pop);

        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) entry0_d = push_data;
                    else                 entry1_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // Entries shift toward the head so the output stays a flop.
                    if (count_q == 2'd1) begin
                        entry0_d = push_data;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = entry0_q;

endmodule

// File: rtl/fetch_control.sv
// fetch_control: instruction fetch stage. Owns the PC, issues one
// outstanding req/ack word fetch at a time, queues returned words with their
// PC+1 in fetch_buffer, and presents the queue head to decode.
//   clk, rst - clock, synchronous active-high reset
//   bus      - fetch_control_if.master (imem handshake, branch redirect,
//              decode stall / instr_valid / instr / pcplus)
module fetch_control #(
    parameter int unsigned          REG_WIDTH = cpu_pkg::REG_WIDTH,
    parameter logic [REG_WIDTH-1:0] RESET_PC  = REG_WIDTH'(cpu_pkg::RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    fetch_control_if.master  bus
);

    import cpu_pkg::*;

    localparam int unsigned ENTRY_W = INSTR_WIDTH + REG_WIDTH;

    fetch_state_e         state_q, state_d;
    logic [REG_WIDTH-1:0] pc_q, pc_d;
    logic                 req;
    logic                 push;
    logic                 pop;
    logic [1:0]           count;
    logic [ENTRY_W-1:0]   head;
    logic [ENTRY_W-1:0]   push_data;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        push      = 1'b0;
        req       = (state_q == ST_FETCH) && (count < 2'd2);
        pop       = (count != 2'd0) && !bus.i_1_stall;
        push_data = {bus.i_16_imem_rdata, pc_q + REG_WIDTH'(1)};

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (req && bus.i_1_imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + REG_WIDTH'(1);
                end
            end
            // Waiting out the wrong-path request; its ack carries no data we keep.
            ST_DRAIN: if (bus.i_1_imem_ack) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase

        // Redirect overrides everything above: no push, PC to target, and an
        // unanswered request must be drained before the new one is issued.
        if (bus.i_1_branch) begin
            push = 1'b0;
            pc_d = bus.i_R_branch_target;
            if (state_q != ST_DRAIN) begin
                state_d = (req && !bus.i_1_imem_ack) ? ST_DRAIN : ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer #(
        .WIDTH (ENTRY_W)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (bus.i_1_branch),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

    assign bus.o_1_imem_req    = req;
    assign bus.o_R_imem_addr   = pc_q;
    assign bus.o_1_instr_valid = (count != 2'd0);
    assign bus.o_16_instr      = head[ENTRY_W-1 -: INSTR_WIDTH];
    assign bus.o_R_pcplus      = head[REG_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: directed bench for fetch_control. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Memory contents are
// modelled as word(addr) = addr ^ 16'h5A5A.
module tb_fetch_control;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_control_if #(.REG_WIDTH(16)) bus ();

    fetch_control #(
        .REG_WIDTH (16),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mw(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [15:0] rdata, input logic br,
                         input logic [15:0] tgt, input logic stall);
        bus.i_1_imem_ack      = ack;
        bus.i_16_imem_rdata   = rdata;
        bus.i_1_branch        = br;
        bus.i_R_branch_target = tgt;
        bus.i_1_stall         = stall;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus.o_R_imem_addr, RST_PC); end
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_1_instr_valid); end
        n_checks++; if (bus.o_16_instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", bus.o_16_instr); end
        n_checks++; if (bus.o_R_pcplus !== 16'h0000) begin n_fail++; $display("FAIL reset_pcplus: got %h want 0000", bus.o_R_pcplus); end
        rst = 1'b0;
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== 16'h0010) begin n_fail++; $display("FAIL first_addr: got %h want 0010", bus.o_R_imem_addr); end
    endtask

    // Zero-wait memory, no stall: one word per cycle, latency one cycle after ack.
    task automatic test_stream();
        logic [15:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 16'h0010 + 16'(i);
            drive(1'b1, mw(a), 1'b0, 16'h0, 1'b0);
            tick();
            n_checks++; if (bus.o_R_imem_addr !== a + 16'h1) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", i, bus.o_R_imem_addr, a + 16'h1); end
            n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req[%0d]: got %b want 1", i, bus.o_1_imem_req); end
            n_checks++; if (bus.o_1_instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.o_1_instr_valid); end
            n_checks++; if (bus.o_16_instr !== mw(a)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.o_16_instr, mw(a)); end
            n_checks++; if (bus.o_R_pcplus !== a + 16'h1) begin n_fail++; $display("FAIL stream_pcplus[%0d]: got %h want %h", i, bus.o_R_pcplus, a + 16'h1); end
        end
    endtask

    // Head holds (word 0x15) across four stalled cycles; queue fills, req drops.
    task automatic test_stall();
        drive(1'b1, mw(16'h0016), 1'b0, 16'h0, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.o_1_imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", k, bus.o_1_imem_req); end
            n_checks++; if (bus.o_1_instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", k, bus.o_1_instr_valid); end
            n_checks++; if (bus.o_16_instr !== mw(16'h0015)) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", k, bus.o_16_instr, mw(16'h0015)); end
            n_checks++; if (bus.o_R_pcplus !== 16'h0016) begin n_fail++; $display("FAIL stall_pcplus[%0d]: got %h want 0016", k, bus.o_R_pcplus); end
            if (k < 3) begin
                drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
                tick();
            end
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_16_instr !== mw(16'h0016)) begin n_fail++; $display("FAIL release_instr: got %h want %h", bus.o_16_instr, mw(16'h0016)); end
        n_checks++; if (bus.o_R_pcplus !== 16'h0017) begin n_fail++; $display("FAIL release_pcplus: got %h want 0017", bus.o_R_pcplus); end
        n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %b want 1", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== 16'h0017) begin n_fail++; $display("FAIL release_addr: got %h want 0017", bus.o_R_imem_addr); end
        drive(1'b1, mw(16'h0017), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_16_instr !== mw(16'h0017)) begin n_fail++; $display("FAIL release2_instr: got %h want %h", bus.o_16_instr, mw(16'h0017)); end
        n_checks++; if (bus.o_R_pcplus !== 16'h0018) begin n_fail++; $display("FAIL release2_pcplus: got %h want 0018", bus.o_R_pcplus); end
    endtask

    // Request to 0x18 waits three cycles; address and req must hold.
    task automatic test_delayed_ack();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
            tick();
            n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req[%0d]: got %b want 1", k, bus.o_1_imem_req); end
            n_checks++; if (bus.o_R_imem_addr !== 16'h0018) begin n_fail++; $display("FAIL wait_addr[%0d]: got %h want 0018", k, bus.o_R_imem_addr); end
            n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid[%0d]: got %b want 0", k, bus.o_1_instr_valid); end
        end
        drive(1'b1, mw(16'h0018), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_16_instr !== mw(16'h0018)) begin n_fail++; $display("FAIL late_instr: got %h want %h", bus.o_16_instr, mw(16'h0018)); end
        n_checks++; if (bus.o_R_pcplus !== 16'h0019) begin n_fail++; $display("FAIL late_pcplus: got %h want 0019", bus.o_R_pcplus); end
        n_checks++; if (bus.o_R_imem_addr !== 16'h0019) begin n_fail++; $display("FAIL late_addr: got %h want 0019", bus.o_R_imem_addr); end
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL single_push_valid: got %b want 0", bus.o_1_instr_valid); end
    endtask

    // Branch while the request to 0x19 is unanswered: drain, discard the late word.
    task automatic test_branch_drain();
        drive(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_req: got %b want 0", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== 16'h0040) begin n_fail++; $display("FAIL drain_addr: got %h want 0040", bus.o_R_imem_addr); end
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_hold_req: got %b want 0", bus.o_1_imem_req); end
        drive(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL post_drain_req: got %b want 1", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== 16'h0040) begin n_fail++; $display("FAIL post_drain_addr: got %h want 0040", bus.o_R_imem_addr); end
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_discard_valid: got %b want 0", bus.o_1_instr_valid); end
        drive(1'b1, mw(16'h0040), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_1_instr_valid !== 1'b1) begin n_fail++; $display("FAIL target_valid: got %b want 1", bus.o_1_instr_valid); end
        n_checks++; if (bus.o_16_instr !== mw(16'h0040)) begin n_fail++; $display("FAIL target_instr: got %h want %h", bus.o_16_instr, mw(16'h0040)); end
        n_checks++; if (bus.o_R_pcplus !== 16'h0041) begin n_fail++; $display("FAIL target_pcplus: got %h want 0041", bus.o_R_pcplus); end
    endtask

    // Branch together with stall and ack, then branch with a full queue.
    task automatic test_branch_stall_ack();
        drive(1'b1, 16'hBEEF, 1'b1, 16'h0080, 1'b1);
        tick();
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL bsa_valid: got %b want 0", bus.o_1_instr_valid); end
        n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL bsa_req: got %b want 1", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== 16'h0080) begin n_fail++; $display("FAIL bsa_addr: got %h want 0080", bus.o_R_imem_addr); end
        drive(1'b1, mw(16'h0080), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_16_instr !== mw(16'h0080)) begin n_fail++; $display("FAIL bsa_instr: got %h want %h", bus.o_16_instr, mw(16'h0080)); end
        drive(1'b1, mw(16'h0081), 1'b0, 16'h0, 1'b1);
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b want 0", bus.o_1_imem_req); end
        drive(1'b0, 16'h0, 1'b1, 16'hFFFE, 1'b1);
        tick();
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL full_flush_valid: got %b want 0", bus.o_1_instr_valid); end
        n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL full_flush_req: got %b want 1", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL full_flush_addr: got %h want fffe", bus.o_R_imem_addr); end
    endtask

    // PC wrap from 0xFFFF to 0x0000.
    task automatic test_wrap();
        drive(1'b1, mw(16'hFFFE), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_R_pcplus !== 16'hFFFF) begin n_fail++; $display("FAIL wrap0_pcplus: got %h want ffff", bus.o_R_pcplus); end
        drive(1'b1, mw(16'hFFFF), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_16_instr !== mw(16'hFFFF)) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", bus.o_16_instr, mw(16'hFFFF)); end
        n_checks++; if (bus.o_R_pcplus !== 16'h0000) begin n_fail++; $display("FAIL wrap_pcplus: got %h want 0000", bus.o_R_pcplus); end
        n_checks++; if (bus.o_R_imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got %h want 0000", bus.o_R_imem_addr); end
        drive(1'b1, mw(16'h0000), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_R_pcplus !== 16'h0001) begin n_fail++; $display("FAIL wrap1_pcplus: got %h want 0001", bus.o_R_pcplus); end
    endtask

    // Branch against a simultaneous pop, then a second branch while draining.
    task automatic test_branch_in_drain();
        drive(1'b0, 16'h0, 1'b1, 16'h0100, 1'b0);
        tick();
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL bpop_valid: got %b want 0", bus.o_1_instr_valid); end
        n_checks++; if (bus.o_1_imem_req !== 1'b0) begin n_fail++; $display("FAIL bpop_req: got %b want 0", bus.o_1_imem_req); end
        drive(1'b0, 16'h0, 1'b1, 16'h0200, 1'b0);
        tick();
        n_checks++; if (bus.o_R_imem_addr !== 16'h0200) begin n_fail++; $display("FAIL redrain_addr: got %h want 0200", bus.o_R_imem_addr); end
        n_checks++; if (bus.o_1_imem_req !== 1'b0) begin n_fail++; $display("FAIL redrain_req: got %b want 0", bus.o_1_imem_req); end
        drive(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL redrain_done_req: got %b want 1", bus.o_1_imem_req); end
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL redrain_valid: got %b want 0", bus.o_1_instr_valid); end
        drive(1'b1, mw(16'h0200), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_16_instr !== mw(16'h0200)) begin n_fail++; $display("FAIL redrain_instr: got %h want %h", bus.o_16_instr, mw(16'h0200)); end
        n_checks++; if (bus.o_R_pcplus !== 16'h0201) begin n_fail++; $display("FAIL redrain_pcplus: got %h want 0201", bus.o_R_pcplus); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        drive(1'b1, mw(16'h0201), 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b want 0", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== RST_PC) begin n_fail++; $display("FAIL mid_rst_addr: got %h want %h", bus.o_R_imem_addr, RST_PC); end
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.o_1_instr_valid); end
        n_checks++; if (bus.o_16_instr !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_instr: got %h want 0000", bus.o_16_instr); end
        n_checks++; if (bus.o_R_pcplus !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_pcplus: got %h want 0000", bus.o_R_pcplus); end
        rst = 1'b0;
        drive(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
        tick();
        n_checks++; if (bus.o_1_imem_req !== 1'b1) begin n_fail++; $display("FAIL restart_req: got %b want 1", bus.o_1_imem_req); end
        n_checks++; if (bus.o_R_imem_addr !== RST_PC) begin n_fail++; $display("FAIL restart_addr: got %h want %h", bus.o_R_imem_addr, RST_PC); end
        n_checks++; if (bus.o_1_instr_valid !== 1'b0) begin n_fail++; $display("FAIL restart_valid: got %b want 0", bus.o_1_instr_valid); end
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_delayed_ack();
        test_branch_drain();
        test_branch_stall_ack();
        test_wrap();
        test_branch_in_drain();
        test_reset_mid();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
